// File: rtl/detector_pkg.sv
// Shared definitions for the detector stream packer: FSM states, FIFO word
// layout and pointer-width helper.
package detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    CLOSE = 2'd2
  } state_t;

  // Flag offsets above the data field inside a FIFO word {sop, eop, data}
  localparam int unsigned EOP_OFS = 0;
  localparam int unsigned SOP_OFS = 1;

  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/detector_sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module detector_sync_fifo
  import detector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/detector_stream_packer.sv
// Packs the delayed detector pixel bus into a ready/valid stream with sop/eop
// marks, buffered in a FIFO; also measures frame geometry and flags drops.
module detector_stream_packer
  import detector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  fval,
  input  logic                  lval,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_sop,
  output logic                  dout_eop,
  output logic [CNT_WIDTH-1:0]  frame_width,
  output logic [CNT_WIDTH-1:0]  frame_height,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned WW = DATA_WIDTH + 2;

  state_t                state;
  logic                  fval_r, fval_d, lval_r, lval_d;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  hold_full, hold_sop, sop_arm;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [CNT_WIDTH-1:0]  pix_cnt, line_cnt;

  logic                  fval_rise, fval_fall, lval_rise, pix, start, active;
  logic                  push, fifo_pop, fifo_full, fifo_empty;
  logic [WW-1:0]         push_word, fifo_rdata;

  always_comb begin
    fval_rise = fval_r & ~fval_d;
    fval_fall = ~fval_r & fval_d;
    lval_rise = lval_r & ~lval_d;
    pix       = fval_r & lval_r;
    start     = (state == IDLE) & fval_rise & enable;
    active    = (state == FRAME) | start;
    push      = 1'b0;
    push_word = '0;
    push_word[DATA_WIDTH-1:0]       = hold_data;
    push_word[DATA_WIDTH + SOP_OFS] = hold_sop;
    if ((state == FRAME) && fval_fall && hold_full) begin
      push = 1'b1;
      push_word[DATA_WIDTH + EOP_OFS] = 1'b1;
    end else if (active && pix && hold_full) begin
      push = 1'b1;
    end
  end

  assign fifo_pop   = dout_ready & ~fifo_empty;
  assign dout_valid = ~fifo_empty;
  assign dout_data  = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
  assign dout_sop   = ~fifo_empty & fifo_rdata[DATA_WIDTH + SOP_OFS];
  assign dout_eop   = ~fifo_empty & fifo_rdata[DATA_WIDTH + EOP_OFS];

  // fval history resets high so a frame already in progress at reset release
  // never looks like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fval_r       <= 1'b1;
      fval_d       <= 1'b1;
      lval_r       <= 1'b0;
      lval_d       <= 1'b0;
      data_r       <= '0;
      hold_full    <= 1'b0;
      hold_sop     <= 1'b0;
      hold_data    <= '0;
      sop_arm      <= 1'b0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      fval_r     <= fval;
      fval_d     <= fval_r;
      lval_r     <= lval;
      lval_d     <= lval_r;
      data_r     <= datain;
      frame_done <= 1'b0;

      if (push && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (err_clr)                   overflow <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= FRAME;
            sop_arm <= 1'b1;
          end
        end
        FRAME: begin
          if (fval_fall) begin
            hold_full <= 1'b0;
            state     <= CLOSE;
          end
        end
        CLOSE: begin
          frame_done   <= 1'b1;
          frame_width  <= pix_cnt;
          frame_height <= line_cnt;
          pix_cnt      <= '0;
          line_cnt     <= '0;
          hold_full    <= 1'b0;
          hold_sop     <= 1'b0;
          sop_arm      <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (active && pix) begin
        hold_full <= 1'b1;
        hold_data <= data_r;
        hold_sop  <= start | sop_arm;
        sop_arm   <= 1'b0;
        if (lval_rise) begin
          pix_cnt <= CNT_WIDTH'(1);
          if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
        end else if (pix_cnt != '1) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

  detector_sync_fifo #(
    .DATA_WIDTH(WW),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(push_word),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_detector_stream_packer.sv
// Randomized self-checking bench for detector_stream_packer; expected words
// come from a frame-level model (sop on first pixel, eop on last).
module tb_detector_stream_packer;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned FD = 4;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          err_clr = 1'b0;
  logic [DW-1:0] datain = '0;
  logic          fval = 1'b0;
  logic          lval = 1'b0;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_sop, dout_eop;
  logic [CW-1:0] frame_width, frame_height;
  logic          frame_done, overflow;

  int compared = 0;
  int mism = 0;

  logic [DW+1:0] rx_q[$];
  int            done_cnt = 0;
  logic [DW-1:0] px[$];
  int            line_w[$];

  detector_stream_packer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .CNT_WIDTH (CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
    .datain(datain), .fval(fval), .lval(lval),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sop(dout_sop), .dout_eop(dout_eop),
    .frame_width(frame_width), .frame_height(frame_height),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid && dout_ready) rx_q.push_back({dout_sop, dout_eop, dout_data});
    if (frame_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: sequential data from sv; mode 1: random data
  task automatic drive_frame(input int mode, input int sv, input int lead, input int post);
    px.delete();
    fval = 1'b1; lval = 1'b0;
    repeat (lead) tick();
    foreach (line_w[l]) begin
      for (int p = 0; p < line_w[l]; p++) begin
        lval = 1'b1;
        datain = mode ? DW'($urandom) : DW'(sv + px.size());
        px.push_back(datain);
        tick();
      end
      lval = 1'b0; datain = '0;
      tick(); tick();
    end
    fval = 1'b0;
    repeat (post) tick();
  endtask

  task automatic model(output logic [DW+1:0] q[$], output int w, output int h);
    int n;
    q.delete();
    n = px.size();
    for (int i = 0; i < n; i++) q.push_back({1'(i == 0), 1'(i == n - 1), px[i]});
    w = (line_w.size() == 0) ? 0 : line_w[line_w.size()-1];
    if (w > int'(SAT)) w = SAT;
    h = (line_w.size() > int'(SAT)) ? SAT : line_w.size();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    compared++; if (dout_valid !== 1'b0) begin mism++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    compared++; if ({dout_sop, dout_eop, dout_data} !== '0) begin mism++; $display("FAIL reset_out got %h want 0", {dout_sop, dout_eop, dout_data}); end
    compared++; if ({frame_width, frame_height, frame_done, overflow} !== '0) begin
      mism++; $display("FAIL reset_status got %h want 0", {frame_width, frame_height, frame_done, overflow}); end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    logic [DW+1:0] exp[$]; int w, h;
    int b = rx_q.size(); int d = done_cnt;
    line_w = '{4, 4, 4};
    drive_frame(0, 1, 1, 8);
    model(exp, w, h);
    compared++; if (rx_q.size() - b != exp.size()) begin mism++; $display("FAIL basic_count got %0d want %0d", rx_q.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < rx_q.size(); i++) begin
      compared++; if (rx_q[b+i] !== exp[i]) begin mism++; $display("FAIL basic_word%0d got %h want %h", i, rx_q[b+i], exp[i]); end
    end
    compared++; if (frame_width !== CW'(w)) begin mism++; $display("FAIL basic_width got %0d want %0d", frame_width, w); end
    compared++; if (frame_height !== CW'(h)) begin mism++; $display("FAIL basic_height got %0d want %0d", frame_height, h); end
    compared++; if (done_cnt - d != 1) begin mism++; $display("FAIL basic_done got %0d want 1", done_cnt - d); end
    compared++; if (overflow !== 1'b0) begin mism++; $display("FAIL basic_overflow got %b want 0", overflow); end
  endtask

  task automatic test_single();
    int b = rx_q.size();
    line_w = '{1};
    drive_frame(0, 16'hABCD, 1, 8);
    compared++; if (rx_q.size() - b != 1) begin mism++; $display("FAIL single_count got %0d want 1", rx_q.size() - b); end
    if (rx_q.size() > b) begin
      compared++; if (rx_q[b] !== {2'b11, 16'hABCD}) begin mism++; $display("FAIL single_word got %h want %h", rx_q[b], {2'b11, 16'hABCD}); end
    end
    compared++; if ({frame_width, frame_height} !== {CW'(1), CW'(1)}) begin
      mism++; $display("FAIL single_geom got %0d/%0d want 1/1", frame_width, frame_height); end
  endtask

  task automatic test_zero();
    int b = rx_q.size(); int d = done_cnt;
    line_w.delete();
    drive_frame(0, 0, 10, 8);
    compared++; if (rx_q.size() != b) begin mism++; $display("FAIL zero_count got %0d want 0", rx_q.size() - b); end
    compared++; if (done_cnt - d != 1) begin mism++; $display("FAIL zero_done got %0d want 1", done_cnt - d); end
    compared++; if ({frame_width, frame_height} !== '0) begin mism++; $display("FAIL zero_geom got %0d/%0d want 0/0", frame_width, frame_height); end
  endtask

  task automatic test_overflow();
    int b = rx_q.size();
    dout_ready = 1'b0;
    line_w = '{4, 4, 4};
    drive_frame(0, 1, 1, 4);
    compared++; if (overflow !== 1'b1) begin mism++; $display("FAIL ovf_flag got %b want 1", overflow); end
    compared++; if (dout_valid !== 1'b1) begin mism++; $display("FAIL ovf_valid got %b want 1", dout_valid); end
    compared++; if ({frame_width, frame_height} !== {CW'(4), CW'(3)}) begin
      mism++; $display("FAIL ovf_geom got %0d/%0d want 4/3", frame_width, frame_height); end
    dout_ready = 1'b1;
    repeat (8) tick();
    compared++; if (rx_q.size() - b != int'(FD)) begin mism++; $display("FAIL ovf_drain got %0d want %0d", rx_q.size() - b, FD); end
    for (int i = 0; i < int'(FD) && b + i < rx_q.size(); i++) begin
      compared++; if (rx_q[b+i] !== {1'(i == 0), 1'b0, DW'(i + 1)}) begin
        mism++; $display("FAIL ovf_word%0d got %h want %h", i, rx_q[b+i], {1'(i == 0), 1'b0, DW'(i + 1)}); end
    end
    compared++; if (overflow !== 1'b1) begin mism++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    compared++; if (overflow !== 1'b0) begin mism++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_enable();
    logic [DW+1:0] exp[$]; int w, h;
    int b = rx_q.size(); int d = done_cnt;
    enable = 1'b0; fval = 1'b1; lval = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 3; p++) begin lval = 1'b1; datain = DW'($urandom); tick(); end
      lval = 1'b0; tick(); tick();
    end
    fval = 1'b0;
    repeat (8) tick();
    compared++; if (rx_q.size() != b) begin mism++; $display("FAIL en_ignored got %0d want 0", rx_q.size() - b); end
    compared++; if (done_cnt != d) begin mism++; $display("FAIL en_done got %0d want 0", done_cnt - d); end
    line_w = '{3, 2};
    drive_frame(1, 0, 1, 8);
    model(exp, w, h);
    compared++; if (rx_q.size() - b != exp.size()) begin mism++; $display("FAIL en_count got %0d want %0d", rx_q.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < rx_q.size(); i++) begin
      compared++; if (rx_q[b+i] !== exp[i]) begin mism++; $display("FAIL en_word%0d got %h want %h", i, rx_q[b+i], exp[i]); end
    end
  endtask

  task automatic test_rst_midframe();
    logic [DW+1:0] exp[$]; int w, h; int b, d;
    fval = 1'b1; lval = 1'b0; tick();
    for (int p = 0; p < 5; p++) begin lval = 1'b1; datain = DW'(p + 100); tick(); end
    rst = 1'b1; tick(); rst = 1'b0;
    compared++; if (dout_valid !== 1'b0) begin mism++; $display("FAIL rst_valid got %b want 0", dout_valid); end
    compared++; if ({frame_width, frame_height, overflow} !== '0) begin
      mism++; $display("FAIL rst_status got %h want 0", {frame_width, frame_height, overflow}); end
    b = rx_q.size(); d = done_cnt;
    for (int p = 0; p < 3; p++) begin datain = DW'(p + 200); tick(); end
    lval = 1'b0; tick(); tick();
    fval = 1'b0;
    repeat (8) tick();
    compared++; if (rx_q.size() != b) begin mism++; $display("FAIL rst_rest got %0d want 0", rx_q.size() - b); end
    compared++; if (done_cnt != d) begin mism++; $display("FAIL rst_done got %0d want 0", done_cnt - d); end
    line_w = '{2, 2};
    drive_frame(1, 0, 1, 8);
    model(exp, w, h);
    compared++; if (rx_q.size() - b != exp.size()) begin mism++; $display("FAIL rst_next_count got %0d want %0d", rx_q.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < rx_q.size(); i++) begin
      compared++; if (rx_q[b+i] !== exp[i]) begin mism++; $display("FAIL rst_next_word%0d got %h want %h", i, rx_q[b+i], exp[i]); end
    end
  endtask

  // Frame B rises in the close cycle of A and must be skipped; C is packed.
  task automatic test_back_to_back();
    logic [DW+1:0] exp[$], ea[$], ec[$]; int w, h;
    int b = rx_q.size(); int d = done_cnt;
    line_w = '{2, 3};
    drive_frame(1, 0, 1, 1);
    model(ea, w, h);
    line_w = '{4};
    drive_frame(1, 0, 1, 2);
    line_w = '{1, 2, 3};
    drive_frame(1, 0, 1, 8);
    model(ec, w, h);
    exp = {ea, ec};
    compared++; if (rx_q.size() - b != exp.size()) begin mism++; $display("FAIL b2b_count got %0d want %0d", rx_q.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < rx_q.size(); i++) begin
      compared++; if (rx_q[b+i] !== exp[i]) begin mism++; $display("FAIL b2b_word%0d got %h want %h", i, rx_q[b+i], exp[i]); end
    end
    compared++; if (done_cnt - d != 2) begin mism++; $display("FAIL b2b_done got %0d want 2", done_cnt - d); end
    compared++; if ({frame_width, frame_height} !== {CW'(w), CW'(h)}) begin
      mism++; $display("FAIL b2b_geom got %0d/%0d want %0d/%0d", frame_width, frame_height, w, h); end
  endtask

  task automatic test_random();
    logic [DW+1:0] exp[$]; int w, h; int b, d, nl;
    for (int f = 0; f < 6; f++) begin
      b = rx_q.size(); d = done_cnt;
      line_w.delete();
      nl = (f == 0) ? 17 : int'($urandom_range(1, 5));
      for (int l = 0; l < nl; l++) line_w.push_back((f == 0) ? 1 : int'($urandom_range(1, 20)));
      drive_frame(1, 0, int'($urandom_range(1, 3)), 8);
      model(exp, w, h);
      compared++; if (rx_q.size() - b != exp.size()) begin mism++; $display("FAIL rnd%0d_count got %0d want %0d", f, rx_q.size() - b, exp.size()); end
      for (int i = 0; i < exp.size() && b + i < rx_q.size(); i++) begin
        compared++; if (rx_q[b+i] !== exp[i]) begin mism++; $display("FAIL rnd%0d_word%0d got %h want %h", f, i, rx_q[b+i], exp[i]); end
      end
      compared++; if ({frame_width, frame_height} !== {CW'(w), CW'(h)}) begin
        mism++; $display("FAIL rnd%0d_geom got %0d/%0d want %0d/%0d", f, frame_width, frame_height, w, h); end
      compared++; if (done_cnt - d != 1) begin mism++; $display("FAIL rnd%0d_done got %0d want 1", f, done_cnt - d); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_zero();
    test_overflow();
    test_enable();
    test_rst_midframe();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/detector_stream_packer.md
Name: detector_stream_packer

Overview:
- Downstream stage of the detector delay line. Consumes the aligned detector pixel bus plus frame-valid and line-valid strobes, all delayed by the same cycle count.
- Packs each frame into a ready/valid video stream with start-of-packet and end-of-packet marks.
- Buffers the stream in a FIFO, because the detector cannot be stalled.
- Measures frame geometry and reports overflow.

Parameters:
- DATA_WIDTH, 16, pixel width.
- FIFO_DEPTH, 64, FIFO entries; power of 2, minimum 4.
- CNT_WIDTH, 12, width of the pixel-per-line and line-per-frame counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  allows new frames to start.
- err_clr  in  1  clears the overflow flag.
- datain  in  DATA_WIDTH  pixel data, already delayed.
- fval  in  1  frame valid, aligned with datain.
- lval  in  1  line valid, aligned with datain.
- dout_data  out  DATA_WIDTH  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  sink ready.
- dout_sop  out  1  first pixel of the frame.
- dout_eop  out  1  last pixel of the frame.
- frame_width  out  CNT_WIDTH  pixel count of the last line of the last completed frame.
- frame_height  out  CNT_WIDTH  line count of the last completed frame.
- frame_done  out  1  one-cycle pulse when a frame closes.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high. When rst=1 at a rising edge, everything below returns to its reset value.
- Reset values:
  - FSM = IDLE; hold register empty; FIFO empty; counters 0.
  - dout_valid=0, dout_sop=0, dout_eop=0, dout_data=0.
  - frame_width=0, frame_height=0, frame_done=0, overflow=0.
- Input registering: fval/lval/datain are registered once internally. Edges are detected against the registered copies.
- A pixel is accepted on any cycle where fval_r & lval_r is 1.
- FSM states:
  - IDLE: on an fval rising edge with enable=1, go to FRAME and arm the sop flag. A frame already high while enable=0, or at the release of rst, is ignored until its fval falls.
  - FRAME:
    - Each accepted pixel goes into a 1-word hold register (data, sop).
    - If the hold register is already full when a pixel is accepted, the held word is pushed to the FIFO with eop=0 in that same cycle.
    - On an fval falling edge: if the hold register is full, push it with eop=1; go to CLOSE.
  - CLOSE (one cycle):
    - Pulse frame_done.
    - Load frame_width from the current line pixel counter and frame_height from the lval-rise counter.
    - Clear the counters and the hold register; go to IDLE.
- Zero-pixel frame (fval with no lval): nothing is pushed; frame_done still pulses; frame_width=0, frame_height=0.
- A frame of exactly one pixel gets sop=1 and eop=1 on the same word.
- Counters: the line counter increments on lval rising edges inside FRAME. The pixel counter resets on each lval rise and increments per accepted pixel. Both saturate at all-ones and never wrap.
- fval rising again in the CLOSE cycle: the edge is ignored, the same as in IDLE with enable=0.
- enable dropping mid-frame: the current frame completes normally.
- FIFO:
  - Word is {sop, eop, data}; show-ahead.
  - dout_valid = !empty. A word is popped when dout_valid & dout_ready.
  - Simultaneous push and pop when full is allowed: the pop frees the slot.
- Push when full (and no pop): the word is dropped and overflow is set. overflow stays at 1 until err_clr or rst; if err_clr and a drop happen in the same cycle, the drop wins.
- Latency: a pixel accepted in cycle N (registered input) appears on dout no earlier than N+3 when the FIFO is empty and dout_ready=1. The N+3 figure assumes the next pixel arrives at N+1.
- Outputs are registered or come straight from FIFO storage. No combinational path from dout_ready to dout_valid.

Decomposition:
- Package detector_pkg:
  - FSM state encoding (IDLE, FRAME, CLOSE).
  - Bit positions of sop and eop inside the FIFO word.
  - A function giving log2 of FIFO_DEPTH for the pointer width.
- Sub-module detector_sync_fifo:
  - Single-clock, show-ahead, parameters DATA_WIDTH and DEPTH.
  - Outputs full and empty.
  - Synchronous active-high reset.

Test Plan:
- 4x3 frame (fval high, three lval bursts of 4 pixels with 2-cycle gaps, data 1..12), dout_ready=1 → 12 words out in order 1..12; sop only on 1; eop only on 12; frame_done pulses once; frame_width=4; frame_height=3; overflow=0.
- Single-pixel frame with data 0xABCD → one word 0xABCD with sop=1 and eop=1; frame_width=1; frame_height=1.
- FIFO_DEPTH=4, dout_ready=0, 4x3 frame → first 4 words retained; overflow=1; then with dout_ready=1, words 1..4 drain and eop is never seen. Pulse err_clr → overflow=0.
- enable=0 at an fval rise, then enable=1 mid-frame → no output for that frame; the next frame with enable=1 is packed normally with sop.
- rst asserted for one cycle mid-frame after 5 pixels → dout_valid=0, FIFO empty, FSM IDLE. The remainder of that frame is ignored; the next frame outputs correctly.
- fval high with no lval for 10 cycles → no words; frame_done pulses; frame_width=0; frame_height=0.
